// File: rtl/route_interlock_pkg.sv
// Shared types and elaboration helpers for the route interlock controller.
// Holds the per-route state encoding, counter sizing and conflict folding.
package route_interlock_pkg;

    localparam int MAX_ROUTES = 32;
    localparam int MAX_BITS   = MAX_ROUTES * MAX_ROUTES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_RELEASE = 2'd3
    } route_state_e;

    // Width able to hold the larger of the two hold counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Fold the matrix so i->j implies j->i; self-conflicts are dropped.
    function automatic logic [MAX_BITS-1:0] conflict_sym(
        input logic [MAX_BITS-1:0] c,
        input int                  n
    );
        logic [MAX_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                if ((i != j) && (c[i*n+j] || c[j*n+i])) begin
                    m[i*n+j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/route_interlock_ctrl_route_fsm.sv
// Single-route sequencer: setup, clear, approach release, idle.
// Owns its state and hold counter; outputs are registered.
module route_fsm
    import route_interlock_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 16,
    parameter int CW             = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_admit,
    input  logic i_req,
    input  logic i_occupied,
    output logic o_locked,
    output logic o_grant
);

    localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] C_REL   = CW'(RELEASE_CYCLES - 1);

    route_state_e  r_state;
    logic [CW-1:0] r_cnt;
    logic          r_locked;
    logic          r_grant;

    // Route sequencer; the signal only clears from an unoccupied section.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_locked <= 1'b0;
            r_grant  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_admit) begin
                        r_state  <= ST_SETUP;
                        r_cnt    <= C_SETUP;
                        r_locked <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (!i_req) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_locked <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!i_occupied) begin
                        r_state <= ST_CLEAR;
                        r_grant <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!i_req || i_occupied) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= C_REL;
                        r_grant <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (i_occupied) begin
                        r_cnt <= C_REL;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_locked <= 1'b0;
                    r_grant  <= 1'b0;
                end
            endcase
        end
    end

    assign o_locked = r_locked;
    assign o_grant  = r_grant;

endmodule

// File: rtl/route_interlock_ctrl.sv
// Clocked route interlock: conflict blocking, round-robin admission
// of one route per cycle, and one sequencer per route.
module route_interlock_ctrl
    import route_interlock_pkg::*;
#(
    parameter int                          N_ROUTES       = 8,
    parameter logic [N_ROUTES*N_ROUTES-1:0] CONFLICT      = '0,
    parameter int                          SETUP_CYCLES   = 4,
    parameter int                          RELEASE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_ROUTES-1:0] i_req,
    input  logic [N_ROUTES-1:0] i_occupied,
    output logic [N_ROUTES-1:0] o_locked,
    output logic [N_ROUTES-1:0] o_grant,
    output logic                o_busy
);

    localparam int CW = cnt_width(SETUP_CYCLES, RELEASE_CYCLES);
    localparam int PW = (N_ROUTES > 1) ? $clog2(N_ROUTES) : 1;
    localparam logic [MAX_BITS-1:0] CMASK =
        conflict_sym(MAX_BITS'(CONFLICT), N_ROUTES);

    logic [N_ROUTES-1:0] w_locked;
    logic [N_ROUTES-1:0] w_grant;
    logic [N_ROUTES-1:0] w_blocked;
    logic [N_ROUTES-1:0] w_cand;
    logic [N_ROUTES-1:0] w_admit;
    logic                w_win_vld;
    logic [PW-1:0]       w_win_idx;
    logic [PW-1:0]       r_ptr;

    // A route is blocked while any conflicting route holds a reservation.
    always_comb begin
        w_blocked = '0;
        for (int r = 0; r < N_ROUTES; r++) begin
            for (int j = 0; j < N_ROUTES; j++) begin
                if (CMASK[r*N_ROUTES+j] && w_locked[j]) begin
                    w_blocked[r] = 1'b1;
                end
            end
        end
    end

    assign w_cand = i_req & ~w_locked & ~i_occupied & ~w_blocked;

    // First candidate at or after the pointer, wrapping, wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int k = 0; k < N_ROUTES; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_ROUTES) begin
                idx = idx - N_ROUTES;
            end
            if (!w_win_vld && w_cand[idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = PW'(idx);
            end
        end
    end

    // One-hot admit pulse to the winning sequencer.
    always_comb begin
        w_admit = '0;
        for (int r = 0; r < N_ROUTES; r++) begin
            if (w_win_vld && (w_win_idx == PW'(r))) begin
                w_admit[r] = 1'b1;
            end
        end
    end

    // Pointer moves past each winner; idle cycles leave it in place.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_win_vld) begin
            if (w_win_idx == PW'(N_ROUTES - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win_idx + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_ROUTES; g++) begin : g_route
        route_fsm #(
            .SETUP_CYCLES   (SETUP_CYCLES),
            .RELEASE_CYCLES (RELEASE_CYCLES),
            .CW             (CW)
        ) u_fsm (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_admit    (w_admit[g]),
            .i_req      (i_req[g]),
            .i_occupied (i_occupied[g]),
            .o_locked   (w_locked[g]),
            .o_grant    (w_grant[g])
        );
    end

    assign o_locked = w_locked;
    assign o_grant  = w_grant;
    // OR of the registered per-route locks.
    assign o_busy   = |w_locked;

endmodule

// File: tb/tb_route_interlock_ctrl.sv
// Bench for route_interlock_ctrl: vector table with an output scoreboard,
// plus sequences for blocking, round-robin, train passage and reset.
module tb_route_interlock_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_req;
    logic [3:0] i_occupied;
    logic [3:0] o_locked;
    logic [3:0] o_grant;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    route_interlock_ctrl #(
        .N_ROUTES       (4),
        .CONFLICT       (16'h0042),
        .SETUP_CYCLES   (4),
        .RELEASE_CYCLES (16)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_occupied (i_occupied),
        .o_locked   (o_locked),
        .o_grant    (o_grant),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] occ;
        logic [3:0] lk;
        logic [3:0] gr;
    } vec_t;

    typedef struct packed {
        logic [3:0] lk;
        logic [3:0] gr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   rr_q[$];
    logic [3:0] prev_occ;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] req,
                       input logic [3:0] occ, input logic [3:0] lk,
                       input logic [3:0] gr);
        vec_t v;
        v = '{rst: rst, req: req, occ: occ, lk: lk, gr: gr};
        vecs.push_back(v);
    endtask

    task automatic step(input logic [3:0] req, input logic [3:0] occ);
        i_req      = req;
        i_occupied = occ;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n    = 1'b0;
        i_req      = 4'b0000;
        i_occupied = 4'b0000;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_state", 32'({o_locked, o_grant, o_busy}), 32'd0);
        i_rst_n = 1'b1;
    endtask

    always @(posedge i_clk) prev_occ <= i_occupied;

    // Safety invariants, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            check("inv_conflict",
                  32'((o_locked[0] & o_locked[1]) | (o_locked[1] & o_locked[2])),
                  32'd0);
            check("inv_grant_lock", 32'(o_grant & ~o_locked), 32'd0);
            check("inv_grant_occ", 32'(o_grant & prev_occ), 32'd0);
            check("inv_busy", 32'(o_busy), 32'(|o_locked));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        logic [3:0] drop;
        logic [3:0] prev_g;
        logic [3:0] rise;

        i_rst_n    = 1'b0;
        i_req      = 4'b0000;
        i_occupied = 4'b0000;

        // Uncontested request on route 0.
        add(1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        add(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        add(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        add(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        add(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        add(1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add(1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        // Simultaneous 0 and 2, later 1 blocked by both.
        add(1'b1, 4'b0101, 4'b0000, 4'b0001, 4'b0000);
        add(1'b0, 4'b0101, 4'b0000, 4'b0101, 4'b0000);
        add(1'b0, 4'b0111, 4'b0000, 4'b0101, 4'b0000);
        add(1'b0, 4'b0111, 4'b0000, 4'b0101, 4'b0000);
        add(1'b0, 4'b0111, 4'b0000, 4'b0101, 4'b0001);
        add(1'b0, 4'b0111, 4'b0000, 4'b0101, 4'b0101);
        add(1'b0, 4'b0111, 4'b0000, 4'b0101, 4'b0101);
        add(1'b0, 4'b0110, 4'b0000, 4'b0101, 4'b0100);
        add(1'b0, 4'b0110, 4'b0000, 4'b0101, 4'b0100);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            e = '{lk: vecs[i].lk, gr: vecs[i].gr};
            sb.push_back(e);
            step(vecs[i].req, vecs[i].occ);
            e = sb.pop_front();
            check($sformatf("vec%0d", i), 32'({o_locked, o_grant}),
                  32'({e.lk, e.gr}));
        end

        // Conflict block, then hand-over after route 0 release.
        do_reset();
        for (int k = 0; k < 5; k++) step(4'b0001, 4'b0000);
        check("cb_grant0", 32'(o_grant), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 4'b0000);
            check("cb_r1_blocked", 32'(o_locked), 32'h1);
        end
        step(4'b0010, 4'b0000);
        check("cb_release", 32'({o_locked, o_grant}), 32'h10);
        n = 0;
        while (o_locked[0] && n < 40) begin
            step(4'b0010, 4'b0000);
            n++;
        end
        check("cb_release_len", 32'(n), 32'd16);
        check("cb_all_idle", 32'(o_locked), 32'h0);
        step(4'b0010, 4'b0000);
        check("cb_r1_locked", 32'(o_locked), 32'h2);

        // Round robin between conflicting routes 0 and 1.
        do_reset();
        rr_q.push_back(0);
        rr_q.push_back(1);
        rr_q.push_back(0);
        rr_q.push_back(1);
        drop   = 4'b0000;
        prev_g = 4'b0000;
        n      = 0;
        while (rr_q.size() > 0 && n < 400) begin
            step(~drop & 4'b0011, 4'b0000);
            n++;
            rise = o_grant & ~prev_g;
            for (int r = 0; r < 4; r++) begin
                if (rise[r] && rr_q.size() > 0) begin
                    check("rr_order", 32'(r), 32'(rr_q.pop_front()));
                end
            end
            drop   = o_grant;
            prev_g = o_grant;
        end
        check("rr_pending", 32'(rr_q.size()), 32'd0);

        // Train passage on route 3 with reoccupation mid-count.
        do_reset();
        for (int k = 0; k < 5; k++) step(4'b1000, 4'b0000);
        check("tp_grant3", 32'(o_grant), 32'h8);
        step(4'b0000, 4'b1000);
        check("tp_grant_drop", 32'({o_locked, o_grant}), 32'h80);
        for (int k = 0; k < 9; k++) step(4'b0000, 4'b1000);
        for (int k = 0; k < 5; k++) step(4'b0000, 4'b0000);
        check("tp_still_locked", 32'({o_locked, o_grant}), 32'h80);
        step(4'b0000, 4'b1000);
        n = 0;
        while (o_locked[3] && n < 40) begin
            step(4'b0000, 4'b0000);
            n++;
        end
        check("tp_restart_len", 32'(n), 32'd16);

        // Asynchronous reset mid-SETUP and mid-CLEAR.
        do_reset();
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0000);
        check("ar_setup_locked", 32'(o_locked), 32'h1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("ar_setup_drop", 32'({o_locked, o_grant, o_busy}), 32'd0);
        i_req = 4'b0000;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step(4'b0001, 4'b0000);
        check("ar_clear_grant", 32'(o_grant), 32'h1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("ar_clear_drop", 32'({o_locked, o_grant, o_busy}), 32'd0);
        i_req = 4'b0000;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(4'b0001, 4'b0000);
        check("ar_fresh_lock", 32'({o_locked, o_grant}), 32'h10);
        n = 1;
        while (!o_grant[0] && n < 20) begin
            step(4'b0001, 4'b0000);
            n++;
        end
        check("ar_fresh_latency", 32'(n), 32'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
